// File: rtl/output_drain_pkg.sv
// rtl/output_drain_pkg.sv - shared widths and FSM state type for the output drain
package output_drain_pkg;

  localparam int DATA_W = 512;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 6;
  localparam int FIFO_D = 2;
  localparam int LANES  = DATA_W / LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/output_drain_fifo.sv
// rtl/output_drain_fifo.sv - small read-data FIFO absorbing output-buffer read latency
module drain_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 512,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through a non-zero count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/output_drain.sv
// rtl/output_drain.sv - drains result rows from the output buffer onto a valid/ready stream
module output_drain
  import output_drain_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   NUM_ROWS,
  input  logic              RELU_EN,
  output logic              obuf_cen,
  output logic              obuf_wen,
  output logic              obuf_ren,
  output logic [ADDR_W-1:0] obuf_addr,
  input  logic [DATA_W-1:0] obuf_q,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CW = $clog2(FIFO_D + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic              relu_q, relu_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   popped_q, popped_d;
  logic              inflight_q;
  logic              done_q;

  logic              issue;
  logic              pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] relu_data;

  // A read is only issued when its data is guaranteed a FIFO slot on arrival.
  always_comb begin
    pop   = !fifo_empty && m_ready;
    issue = (state_q == READ) && (issued_q != num_q) &&
            ((int'(fifo_count) + int'(inflight_q) - int'(pop)) < FIFO_D);
  end

  always_comb begin
    relu_data = obuf_q;
    for (int l = 0; l < LANES; l++) begin
      if (relu_q && obuf_q[l*LANE_W + LANE_W - 1]) relu_data[l*LANE_W +: LANE_W] = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    relu_d   = relu_q;
    issued_d = issue ? issued_q + 1'b1 : issued_q;
    popped_d = pop ? popped_q + 1'b1 : popped_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          base_d   = BASE_ADDR;
          num_d    = NUM_ROWS;
          relu_d   = RELU_EN;
          issued_d = '0;
          popped_d = '0;
          state_d  = (NUM_ROWS != '0) ? READ : FIN;
        end
      end
      READ:    if (issue && (issued_q == num_q - 1'b1)) state_d = FLUSH;
      FLUSH:   if (fifo_empty && !inflight_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      relu_q     <= 1'b0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      relu_q     <= relu_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= issue;
      done_q     <= (state_q == FIN);
    end
  end

  drain_fifo #(.DEPTH(FIFO_D), .W(DATA_W), .CW(CW)) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .push_i      (inflight_q),
    .push_data_i (relu_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign obuf_cen  = !issue;
  assign obuf_wen  = 1'b1;
  assign obuf_ren  = (state_q == READ) || (state_q == FLUSH);
  assign obuf_addr = base_q + issued_q[ADDR_W-1:0];
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_empty ? '0 : fifo_head;
  assign m_last    = !fifo_empty && (popped_q == num_q - 1'b1);
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;

endmodule

// File: tb/tb_output_drain.sv
// tb/tb_output_drain.sv - directed self-checking bench for output_drain
module tb_output_drain;

  logic         CLK = 1'b0;
  logic         RESET, START, RELU_EN, m_ready;
  logic [5:0]   BASE_ADDR;
  logic [6:0]   NUM_ROWS;
  logic         obuf_cen, obuf_wen, obuf_ren, m_valid, m_last, BUSY, DONE;
  logic [5:0]   obuf_addr;
  logic [511:0] obuf_q, m_data;

  logic [511:0] mem [64];

  int tests_run = 0;
  int tests_failed = 0;

  logic [511:0] beat_data [$];
  logic         beat_last [$];
  int           beat_cyc [$];
  logic [5:0]   addr_seq [$];
  int done_cnt, done_cyc, max_out, stall_err, busy_c1;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (!obuf_cen) obuf_q <= mem[obuf_addr];

  output_drain dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR), .NUM_ROWS(NUM_ROWS),
    .RELU_EN(RELU_EN), .obuf_cen(obuf_cen), .obuf_wen(obuf_wen), .obuf_ren(obuf_ren),
    .obuf_addr(obuf_addr), .obuf_q(obuf_q), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .BUSY(BUSY), .DONE(DONE)
  );

  task automatic run_drain(input logic [5:0] base, input logic [6:0] num, input logic relu,
                           input int rmode, input int inj_c, input int ncyc);
    int issued, popped;
    logic stall_pend;
    logic [511:0] stall_data;
    beat_data.delete(); beat_last.delete(); beat_cyc.delete(); addr_seq.delete();
    done_cnt = 0; done_cyc = -1; max_out = 0; stall_err = 0; busy_c1 = 0;
    issued = 0; popped = 0; stall_pend = 1'b0; stall_data = '0;
    @(negedge CLK);
    START = 1'b1; BASE_ADDR = base; NUM_ROWS = num; RELU_EN = relu;
    @(negedge CLK);
    START = 1'b0; BASE_ADDR = ~base; NUM_ROWS = 7'd0; RELU_EN = ~relu;
    for (int c = 1; c <= ncyc; c++) begin
      m_ready = (rmode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      START = (c == inj_c);
      if (c == inj_c) begin BASE_ADDR = 6'd5; NUM_ROWS = 7'd4; end
      #1;
      if (c == 1) busy_c1 = int'(BUSY);
      if (!obuf_cen) begin addr_seq.push_back(obuf_addr); issued++; end
      if (stall_pend && (!m_valid || m_data !== stall_data)) stall_err++;
      stall_pend = 1'b0;
      if (m_valid && m_ready) begin
        beat_data.push_back(m_data); beat_last.push_back(m_last); beat_cyc.push_back(c);
        popped++;
      end else if (m_valid) begin
        stall_pend = 1'b1; stall_data = m_data;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (DONE) begin done_cnt++; done_cyc = c; end
      @(negedge CLK);
    end
    START = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b0; BASE_ADDR = '0; NUM_ROWS = '0; RELU_EN = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge CLK);
    tests_run++; if (obuf_cen !== 1'b1) begin tests_failed++; $display("FAIL reset_cen got %b exp 1", obuf_cen); end
    tests_run++; if (obuf_wen !== 1'b1) begin tests_failed++; $display("FAIL reset_wen got %b exp 1", obuf_wen); end
    tests_run++; if (obuf_ren !== 1'b0) begin tests_failed++; $display("FAIL reset_ren got %b exp 0", obuf_ren); end
    tests_run++; if (obuf_addr !== 6'd0) begin tests_failed++; $display("FAIL reset_addr got %0d exp 0", obuf_addr); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", m_valid); end
    tests_run++; if (m_data !== 512'd0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", m_data); end
    tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last got %b exp 0", m_last); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", DONE); end
    RESET = 1'b0;
  endtask

  task automatic test_basic;
    run_drain(6'd0, 7'd4, 1'b0, 0, 0, 14);
    tests_run++; if (beat_data.size() != 4) begin tests_failed++; $display("FAIL basic_beats got %0d exp 4", beat_data.size()); end
    for (int k = 0; k < 4 && k < beat_data.size(); k++) begin
      tests_run++; if (beat_data[k] !== mem[k]) begin tests_failed++; $display("FAIL basic_data%0d got %h exp %h", k, beat_data[k], mem[k]); end
      tests_run++; if (beat_last[k] !== (k == 3)) begin tests_failed++; $display("FAIL basic_last%0d got %b exp %b", k, beat_last[k], k == 3); end
      tests_run++; if (beat_cyc[k] != 3 + k) begin tests_failed++; $display("FAIL basic_cycle%0d got %0d exp %0d", k, beat_cyc[k], 3 + k); end
    end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    tests_run++; if (done_cyc != 9) begin tests_failed++; $display("FAIL basic_done_cycle got %0d exp 9", done_cyc); end
  endtask

  task automatic test_wrap;
    logic [5:0] exp_a [4];
    exp_a = '{6'd62, 6'd63, 6'd0, 6'd1};
    run_drain(6'd62, 7'd4, 1'b0, 0, 0, 14);
    tests_run++; if (addr_seq.size() != 4) begin tests_failed++; $display("FAIL wrap_reads got %0d exp 4", addr_seq.size()); end
    tests_run++; if (beat_data.size() != 4) begin tests_failed++; $display("FAIL wrap_beats got %0d exp 4", beat_data.size()); end
    for (int k = 0; k < 4 && k < addr_seq.size() && k < beat_data.size(); k++) begin
      tests_run++; if (addr_seq[k] !== exp_a[k]) begin tests_failed++; $display("FAIL wrap_addr%0d got %0d exp %0d", k, addr_seq[k], exp_a[k]); end
      tests_run++; if (beat_data[k] !== mem[exp_a[k]]) begin tests_failed++; $display("FAIL wrap_data%0d got %h exp %h", k, beat_data[k], mem[exp_a[k]]); end
    end
  endtask

  task automatic test_backpressure;
    run_drain(6'd20, 7'd8, 1'b0, 1, 0, 40);
    tests_run++; if (beat_data.size() != 8) begin tests_failed++; $display("FAIL bp_beats got %0d exp 8", beat_data.size()); end
    for (int k = 0; k < 8 && k < beat_data.size(); k++) begin
      tests_run++; if (beat_data[k] !== mem[20 + k]) begin tests_failed++; $display("FAIL bp_data%0d got %h exp %h", k, beat_data[k], mem[20 + k]); end
      tests_run++; if (beat_last[k] !== (k == 7)) begin tests_failed++; $display("FAIL bp_last%0d got %b exp %b", k, beat_last[k], k == 7); end
    end
    tests_run++; if (stall_err != 0) begin tests_failed++; $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_err); end
    tests_run++; if (max_out > 2) begin tests_failed++; $display("FAIL bp_outstanding got %0d exp <=2", max_out); end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL bp_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_relu;
    logic [511:0] exp_on;
    mem[10] = {{12{32'h12345678}}, 32'h7FFFFFFF, 32'h80000000, 32'h00000010, 32'hFFFFFFF0};
    exp_on  = {{12{32'h12345678}}, 32'h7FFFFFFF, 32'h00000000, 32'h00000010, 32'h00000000};
    run_drain(6'd10, 7'd1, 1'b1, 0, 0, 10);
    tests_run++; if (beat_data.size() != 1) begin tests_failed++; $display("FAIL relu_on_beats got %0d exp 1", beat_data.size()); end
    else begin
      tests_run++; if (beat_data[0] !== exp_on) begin tests_failed++; $display("FAIL relu_on_data got %h exp %h", beat_data[0], exp_on); end
    end
    run_drain(6'd10, 7'd1, 1'b0, 0, 0, 10);
    tests_run++; if (beat_data.size() != 1) begin tests_failed++; $display("FAIL relu_off_beats got %0d exp 1", beat_data.size()); end
    else begin
      tests_run++; if (beat_data[0] !== mem[10]) begin tests_failed++; $display("FAIL relu_off_data got %h exp %h", beat_data[0], mem[10]); end
    end
  endtask

  task automatic test_zero_rows;
    run_drain(6'd3, 7'd0, 1'b0, 0, 1, 12);
    tests_run++; if (addr_seq.size() != 0) begin tests_failed++; $display("FAIL zero_reads got %0d exp 0", addr_seq.size()); end
    tests_run++; if (beat_data.size() != 0) begin tests_failed++; $display("FAIL zero_beats got %0d exp 0", beat_data.size()); end
    tests_run++; if (busy_c1 != 1) begin tests_failed++; $display("FAIL zero_busy got %0d exp 1", busy_c1); end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL zero_done_count got %0d exp 1", done_cnt); end
    tests_run++; if (done_cyc != 2) begin tests_failed++; $display("FAIL zero_done_cycle got %0d exp 2", done_cyc); end
  endtask

  task automatic test_reset_mid;
    int n, guard, bad;
    @(negedge CLK);
    START = 1'b1; BASE_ADDR = 6'd0; NUM_ROWS = 7'd16; RELU_EN = 1'b0; m_ready = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 0; guard = 0;
    while (n < 5 && guard < 40) begin
      #1; if (m_valid) n++;
      guard++;
      @(negedge CLK);
    end
    tests_run++; if (n != 5) begin tests_failed++; $display("FAIL mid_beats got %0d exp 5", n); end
    RESET = 1'b1;
    @(negedge CLK);
    tests_run++; if (obuf_cen !== 1'b1 || obuf_wen !== 1'b1 || obuf_ren !== 1'b0 || obuf_addr !== 6'd0)
      begin tests_failed++; $display("FAIL mid_obuf got cen%b wen%b ren%b addr%0d exp 1 1 0 0", obuf_cen, obuf_wen, obuf_ren, obuf_addr); end
    tests_run++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 512'd0)
      begin tests_failed++; $display("FAIL mid_stream got v%b l%b d%h exp 0 0 0", m_valid, m_last, m_data); end
    tests_run++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin tests_failed++; $display("FAIL mid_status got busy%b done%b exp 0 0", BUSY, DONE); end
    RESET = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1; if (DONE || m_valid || !obuf_cen || BUSY) bad++;
      @(negedge CLK);
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL mid_quiet got %0d active cycles exp 0", bad); end
  endtask

  initial begin
    for (int a = 0; a < 64; a++)
      for (int l = 0; l < 16; l++)
        mem[a][l*32 +: 32] = {8'hA5, 8'(a), 8'(l), 8'h3C};
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_relu();
    test_zero_rows();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
